oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Owns the external memory bus between the CPU core and the OAM DMA engine.
- A CPU write to the DMA register (0xFF46) starts a block copy of DMA_LENGTH bytes from {src_hi,8'h00} to DMA_DEST.
- While the copy runs, the DMA engine owns the memory bus. CPU access is limited to HRAM and the DMA register; other CPU reads return 0xFF and other CPU writes are dropped.
- Sits between the CPU core's o_Address/o_Bus/o_Bus_In/o_Bus_Out/i_Bus and the system memory map.

Parameters:
- DMA_LENGTH, 160, bytes per transfer (1..256).
- DMA_DEST, 16'hFE00, destination base address.
- DMA_REG_ADDR, 16'hFF46, address of the DMA start/source register.
- HRAM_BASE, 16'hFF80, first HRAM address.
- HRAM_TOP, 16'hFFFE, last HRAM address.

Ports:
- i_Clk  in  1  system clock
- i_Reset_n  in  1  asynchronous reset, active low
- i_Enable  in  1  clock enable; state advances only on enabled edges
- i_Cpu_Address  in  16  CPU target address
- i_Cpu_Data  in  8  CPU write data
- i_Cpu_Bus_Out  in  1  CPU write strobe
- i_Cpu_Bus_In  in  1  CPU read strobe
- o_Cpu_Data  out  8  read data returned to CPU
- o_Mem_Address  out  16  memory address
- o_Mem_Data  out  8  memory write data
- o_Mem_Read  out  1  memory read strobe
- o_Mem_Write  out  1  memory write strobe
- i_Mem_Data  in  8  memory read data, valid in the same cycle as o_Mem_Read
- o_Hram_Address  out  7  HRAM index (address minus HRAM_BASE)
- o_Hram_Data  out  8  HRAM write data
- o_Hram_Write  out  1  HRAM write strobe
- i_Hram_Data  in  8  HRAM read data, combinational
- o_Dma_Active  out  1  high while DMA owns the bus

Behaviour:

Interface and reset:
- One clock, i_Clk. Reset i_Reset_n is asynchronous, active low.
- Reset values: state=IDLE, index=0, dma_reg=8'hFF, latch=8'h00, o_Dma_Active=0.
- Outputs are combinational from state and inputs. With no CPU strobe active, every strobe output is 0.

State machine (transitions only on edges with i_Enable=1):
- IDLE: on a CPU write to DMA_REG_ADDR, set dma_reg<=i_Cpu_Data, index<=0, go to START.
- START: one enabled cycle. The CPU still owns the bus. Next state is READ.
- READ: drive o_Mem_Address={src_hi,index} and o_Mem_Read=i_Enable. Capture latch<=i_Mem_Data. Next state is WRITE.
- WRITE: drive o_Mem_Address=DMA_DEST+index, o_Mem_Data=latch, o_Mem_Write=i_Enable.
  - If index==DMA_LENGTH-1, go to IDLE.
  - Otherwise index<=index+1 and go to READ.
- Source mapping: src_hi=dma_reg, except dma_reg in 0xE0..0xFF maps to dma_reg-0x20 (echo RAM folding).
- Timing: o_Dma_Active=1 in READ and WRITE only. A full transfer takes 1+2*DMA_LENGTH enabled cycles, i.e. 321 at the default length.

CPU access routing (all states):
- HRAM_BASE..HRAM_TOP goes to the HRAM port: o_Hram_Write=i_Cpu_Bus_Out, and o_Cpu_Data=i_Hram_Data on reads. It is never forwarded to memory.
- DMA_REG_ADDR: reads return dma_reg. Writes update dma_reg and restart the transfer (START, index=0) from any state. It is never forwarded to memory.
- Any other address:
  - In IDLE/START, forward to the memory port (address, data, strobes passthrough; o_Cpu_Data=i_Mem_Data).
  - In READ/WRITE, return o_Cpu_Data=8'hFF and drop writes. No CPU strobe reaches the memory port.

Boundary conditions:
- i_Enable=0: state, index and latch hold, and DMA strobes are 0. CPU passthrough stays combinational.
- Restart mid-transfer: the byte in flight is abandoned. No write is issued for a READ interrupted by the restart.
- CPU write to DMA_REG_ADDR on the final WRITE edge: the restart wins, so the next state is START, not IDLE.
- Reset mid-transfer: immediate return to IDLE with all strobes 0. No further DMA writes occur.
- index width is 8 bits, and it never wraps past DMA_LENGTH-1.

Test Plan:
1. Reset, then CPU write 0xC1 to 0xFF46 → START for 1 cycle, then the first READ addresses 0xC100. The WRITE of that byte goes to 0xFE00 with the data read. The last WRITE goes to 0xFE9F. o_Dma_Active is high for exactly 320 enabled cycles.
2. During DMA, CPU reads 0x8000 → o_Cpu_Data=0xFF and no CPU strobe on the memory port. CPU writes 0x55 to 0xFF90 → o_Hram_Write=1, o_Hram_Address=0x10, o_Hram_Data=0x55.
3. Write 0xE2 to 0xFF46 → source reads start at 0xC200. A later CPU read of 0xFF46 returns 0xE2.
4. At index 50, CPU writes 0x80 to 0xFF46 → START, then READ at 0x8000. Destination restarts at 0xFE00, and there is no write to 0xFE32 after the restart.
5. Toggle i_Enable 1/0 every cycle for a full transfer → 321 enabled cycles to completion. Strobes are asserted only on enabled cycles and the data matches test 1.
6. Assert i_Reset_n low at index 80 → o_Dma_Active=0 immediately, dma_reg reads 0xFF, and CPU access to 0x8000 is passed through.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//
// Arbitrates the external memory bus between the CPU core and the OAM DMA
// engine. A CPU write to the DMA register starts a block copy of DMA_LENGTH
// bytes from {src_hi, 8'h00} to DMA_DEST. While the copy runs the engine owns
// the memory bus. During that time the CPU can still reach HRAM and the DMA
// register. Other CPU reads return 8'hFF and other CPU writes are dropped.
//
// Ports
//   i_Clk, i_Reset_n     clock, asynchronous active-low reset
//   i_Enable             clock enable; state advances only on enabled edges
//   i_Cpu_*              CPU side: address, write data, write/read strobes
//   o_Cpu_Data           read data returned to the CPU
//   o_Mem_*, i_Mem_Data  system memory port (read data valid same cycle)
//   o_Hram_*, i_Hram_Data  HRAM port (index = address - HRAM_BASE)
//   o_Dma_Active         high while the DMA engine owns the memory bus
//
// Transfer timing: START (1 enabled cycle), then READ/WRITE pairs, one pair
// per byte, for a total of 1 + 2*DMA_LENGTH enabled cycles.

module oam_dma_arbiter #(
   parameter int unsigned DMA_LENGTH   = 160,
   parameter logic [15:0] DMA_DEST     = 16'hFE00,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] HRAM_BASE    = 16'hFF80,
   parameter logic [15:0] HRAM_TOP     = 16'hFFFE
) (
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic        i_Enable,
   input  logic [15:0] i_Cpu_Address,
   input  logic [7:0]  i_Cpu_Data,
   input  logic        i_Cpu_Bus_Out,
   input  logic        i_Cpu_Bus_In,
   output logic [7:0]  o_Cpu_Data,
   output logic [15:0] o_Mem_Address,
   output logic [7:0]  o_Mem_Data,
   output logic        o_Mem_Read,
   output logic        o_Mem_Write,
   input  logic [7:0]  i_Mem_Data,
   output logic [6:0]  o_Hram_Address,
   output logic [7:0]  o_Hram_Data,
   output logic        o_Hram_Write,
   input  logic [7:0]  i_Hram_Data,
   output logic        o_Dma_Active
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

   state_t     state_q, state_d;
   logic [7:0] index_q, index_d;
   logic [7:0] dma_reg_q, dma_reg_d;
   logic [7:0] latch_q, latch_d;

   logic       cpu_is_hram;
   logic       cpu_is_reg;
   logic       cpu_is_other;
   logic       reg_write;
   logic       dma_busy;
   logic [7:0] src_hi;

   // ------------------------------------------------------------------
   // Address decode and source mapping
   // ------------------------------------------------------------------
   always_comb begin : decode
      cpu_is_hram  = (i_Cpu_Address >= HRAM_BASE) && (i_Cpu_Address <= HRAM_TOP);
      cpu_is_reg   = (i_Cpu_Address == DMA_REG_ADDR);
      cpu_is_other = !cpu_is_hram && !cpu_is_reg;
      reg_write    = cpu_is_reg && i_Cpu_Bus_Out;
      dma_busy     = (state_q == ST_READ) || (state_q == ST_WRITE);
      // Sources 0xE0..0xFF are echo RAM; fold them onto 0xC0..0xDF.
      if (dma_reg_q >= 8'hE0) begin
         src_hi = dma_reg_q - 8'h20;
      end else begin
         src_hi = dma_reg_q;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q   <= ST_IDLE;
         index_q   <= 8'h00;
         dma_reg_q <= 8'hFF;
         latch_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         dma_reg_q <= dma_reg_d;
         latch_q   <= latch_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state. A register write restarts from any state and takes
   // priority over the end-of-transfer return to IDLE.
   // ------------------------------------------------------------------
   always_comb begin : next_state
      state_d   = state_q;
      index_d   = index_q;
      dma_reg_d = dma_reg_q;
      latch_d   = latch_q;
      if (i_Enable) begin
         if (reg_write) begin
            dma_reg_d = i_Cpu_Data;
            index_d   = 8'h00;
            state_d   = ST_START;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_IDLE;
               end
               ST_START: begin
                  state_d = ST_READ;
               end
               ST_READ: begin
                  latch_d = i_Mem_Data;
                  state_d = ST_WRITE;
               end
               ST_WRITE: begin
                  if (index_q == LAST_INDEX) begin
                     state_d = ST_IDLE;
                  end else begin
                     index_d = index_q + 8'h01;
                     state_d = ST_READ;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Bus routing
   // ------------------------------------------------------------------
   always_comb begin : routing
      o_Cpu_Data     = 8'hFF;
      o_Mem_Address  = 16'h0000;
      o_Mem_Data     = 8'h00;
      o_Mem_Read     = 1'b0;
      o_Mem_Write    = 1'b0;
      o_Hram_Address = i_Cpu_Address[6:0] - HRAM_BASE[6:0];
      o_Hram_Data    = i_Cpu_Data;
      o_Hram_Write   = cpu_is_hram && i_Cpu_Bus_Out;
      o_Dma_Active   = dma_busy;

      // CPU read data: HRAM and the DMA register are always reachable;
      // memory reads are only visible while the CPU owns the bus.
      if (cpu_is_hram) begin
         o_Cpu_Data = i_Hram_Data;
      end else if (cpu_is_reg) begin
         o_Cpu_Data = dma_reg_q;
      end else if (!dma_busy) begin
         o_Cpu_Data = i_Mem_Data;
      end

      case (state_q)
         ST_READ: begin
            o_Mem_Address = {src_hi, index_q};
            o_Mem_Read    = i_Enable;
         end
         ST_WRITE: begin
            o_Mem_Address = DMA_DEST + {8'h00, index_q};
            o_Mem_Data    = latch_q;
            o_Mem_Write   = i_Enable;
         end
         default: begin
            if (cpu_is_other) begin
               o_Mem_Address = i_Cpu_Address;
               o_Mem_Data    = i_Cpu_Data;
               o_Mem_Read    = i_Cpu_Bus_In;
               o_Mem_Write   = i_Cpu_Bus_Out;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: reset/routing vector table, hand-written
// multi-cycle transfer sequences with an expected-transaction queue, and a
// randomized phase checked against a cycle-position reference model.

module tb_oam_dma_arbiter;

   localparam int LEN = 160;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_rdata;
   logic [6:0]  hram_addr;
   logic [7:0]  hram_wdata;
   logic        hram_wr;
   logic [7:0]  hram_rdata;
   logic        dma_active;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] exp_rd_q[$];
   logic [23:0] exp_wr_q[$];
   bit          obs_on = 1'b0;
   int          act_en_cnt = 0;

   logic [7:0] hram_mem [128] = '{default: 8'h00};

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        rd;
      logic        wr;
      logic [7:0]  e_cpu;
      logic        e_mrd;
      logic        e_mwr;
      logic        e_hwr;
   } vec_t;

   vec_t tbl[$];

   oam_dma_arbiter dut (
      .i_Clk          (clk),
      .i_Reset_n      (rst_n),
      .i_Enable       (en),
      .i_Cpu_Address  (cpu_addr),
      .i_Cpu_Data     (cpu_wdata),
      .i_Cpu_Bus_Out  (cpu_wr),
      .i_Cpu_Bus_In   (cpu_rd),
      .o_Cpu_Data     (cpu_rdata),
      .o_Mem_Address  (mem_addr),
      .o_Mem_Data     (mem_wdata),
      .o_Mem_Read     (mem_rd),
      .o_Mem_Write    (mem_wr),
      .i_Mem_Data     (mem_rdata),
      .o_Hram_Address (hram_addr),
      .o_Hram_Data    (hram_wdata),
      .o_Hram_Write   (hram_wr),
      .i_Hram_Data    (hram_rdata),
      .o_Dma_Active   (dma_active)
   );

   // clock / memories
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] src_of(input logic [7:0] r);
      return (r >= 8'hE0) ? r - 8'h20 : r;
   endfunction

   assign mem_rdata  = mem_f(mem_addr);
   assign hram_rdata = hram_mem[hram_addr];

   always @(posedge clk) begin
      if (hram_wr) hram_mem[hram_addr] <= hram_wdata;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // scoreboard helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input logic [31:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h with nothing expected", name, act);
   endtask

   task automatic expect_transfer(input logic [7:0] r, input int nr, input int nw);
      logic [7:0] s;
      s = src_of(r);
      for (int i = 0; i < nr; i++) exp_rd_q.push_back({s, 8'(i)});
      for (int i = 0; i < nw; i++)
         exp_wr_q.push_back({16'hFE00 + 16'(i), mem_f({s, 8'(i)})});
   endtask

   task automatic observe();
      if (!obs_on) return;
      if (dma_active) begin
         if (en) act_en_cnt++;
         chk("dma_strobe_gated", 32'(mem_rd | mem_wr), 32'(en));
         if (mem_rd) begin
            if (exp_rd_q.size() > 0) chk("dma_rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
            else note_fail("dma_rd_extra", 32'(mem_addr));
         end
         if (mem_wr) begin
            if (exp_wr_q.size() > 0) chk("dma_wr_addr_data", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_wr_q.pop_front()});
            else note_fail("dma_wr_extra", {8'h00, mem_addr, mem_wdata});
         end
      end else if (!cpu_rd && !cpu_wr) begin
         chk("idle_no_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      end
   endtask

   // driver: inputs change on the falling edge, outputs sampled 1ns later
   task automatic step(input logic e, input logic [15:0] a, input logic [7:0] d,
                       input logic r, input logic w);
      @(negedge clk);
      en = e; cpu_addr = a; cpu_wdata = d; cpu_rd = r; cpu_wr = w;
      #1;
      observe();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      bit idle_seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
         if (!dma_active) begin
            idle_seen = 1'b1;
            break;
         end
      end
      if (!idle_seen) note_fail("drain_timeout", 32'(dma_active));
      chk("drain_rd_left", 32'(exp_rd_q.size()), 32'd0);
      chk("drain_wr_left", 32'(exp_wr_q.size()), 32'd0);
   endtask

   task automatic run_full(input logic [7:0] r, input bit toggle, input int inject_at,
                           input logic [7:0] inj_d);
      int en_cnt = 0;
      bit seen = 1'b0, done = 1'b0, expect_start = 1'b0;
      bit e, inj;
      act_en_cnt = 0;
      step(1'b1, 16'hFF46, r, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         e   = toggle ? (cyc % 2 == 0) : 1'b1;
         inj = (inject_at > 0) && e && (en_cnt == inject_at);
         step(e, inj ? 16'hFF46 : 16'h0000, inj ? inj_d : 8'h00, 1'b0, inj);
         if (expect_start && e) begin
            chk("restart_start", 32'(dma_active), 32'd0);
            expect_start = 1'b0;
         end
         if (seen && !dma_active) begin
            done = 1'b1;
            break;
         end
         if (dma_active) seen = 1'b1;
         if (e) en_cnt++;
         if (inj) begin
            seen = 1'b0;
            expect_start = 1'b1;
         end
      end
      if (!done) note_fail("dma_timeout", 32'(en_cnt));
      chk("dma_rd_left", 32'(exp_rd_q.size()), 32'd0);
      chk("dma_wr_left", 32'(exp_wr_q.size()), 32'd0);
      if (inject_at == 0) begin
         chk("dma_enabled_cycles", 32'(en_cnt), 32'(1 + 2 * LEN));
         chk("dma_active_cycles", 32'(act_en_cnt), 32'(2 * LEN));
      end
   endtask

   // random phase with reference model
   task automatic random_phase(input int ncyc);
      int          m_pos = -1;
      logic [7:0]  m_reg = 8'hFF;
      logic        e, r, w, hram, isreg, other, busy, rdph, e_rd, e_wr;
      logic [15:0] a, e_addr;
      logic [7:0]  d, idx, e_data, e_cpu;
      int          sel, rw;
      for (int c = 0; c < ncyc; c++) begin
         e = ($urandom_range(0, 3) != 0);
         d = 8'($urandom_range(0, 255));
         r = 1'b0; w = 1'b0;
         if ($urandom_range(0, 399) == 0) begin
            a = 16'hFF46; w = 1'b1;
            if ($urandom_range(0, 1) == 1) d = 8'(8'hE0 + 8'($urandom_range(0, 31)));
         end else begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: a = 16'(16'hFF80 + 16'($urandom_range(0, 127)));
               1: a = 16'hFF46;
               2: a = 16'(16'h8000 + 16'($urandom_range(0, 255)));
               3: a = 16'(16'hC000 + 16'($urandom_range(0, 511)));
               4: a = 16'(16'hFF00 + 16'($urandom_range(0, 127)));
               default: a = 16'($urandom_range(0, 65535));
            endcase
            rw = $urandom_range(0, 3);
            r = (rw == 1) || (rw == 3);
            w = (rw == 2) && (a != 16'hFF46);
         end
         step(e, a, d, r, w);

         hram  = (a >= 16'hFF80) && (a <= 16'hFFFE);
         isreg = (a == 16'hFF46);
         other = !hram && !isreg;
         busy  = (m_pos >= 1) && (m_pos <= 2 * LEN);
         rdph  = busy && (m_pos % 2 == 1);
         idx   = busy ? 8'((m_pos - 1) / 2) : 8'h00;
         e_rd  = busy ? (rdph && e) : (other && r);
         e_wr  = busy ? (!rdph && e) : (other && w);
         e_addr = busy ? (rdph ? {src_of(m_reg), idx} : 16'hFE00 + {8'h00, idx}) : a;
         e_data = busy ? mem_f({src_of(m_reg), idx}) : d;
         e_cpu  = hram ? hram_mem[a[6:0]] : (isreg ? m_reg : (busy ? 8'hFF : mem_f(a)));

         chk("rnd_active", 32'(dma_active), 32'(busy));
         chk("rnd_mem_rd", 32'(mem_rd), 32'(e_rd));
         chk("rnd_mem_wr", 32'(mem_wr), 32'(e_wr));
         if (busy || e_rd || e_wr) chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
         if (e_wr) chk("rnd_mem_data", 32'(mem_wdata), 32'(e_data));
         chk("rnd_cpu_data", 32'(cpu_rdata), 32'(e_cpu));
         chk("rnd_hram_wr", 32'(hram_wr), 32'(hram && w));
         if (hram) chk("rnd_hram_addr", 32'(hram_addr), 32'(a[6:0]));
         if (hram && w) chk("rnd_hram_data", 32'(hram_wdata), 32'(d));

         if (e) begin
            if (isreg && w) begin
               m_reg = d;
               m_pos = 0;
            end else if (m_pos >= 0) begin
               m_pos++;
               if (m_pos > 2 * LEN) m_pos = -1;
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      cpu_rd = 1'b0; cpu_wr = 1'b0;

      // reset state
      step(1'b1, 16'hFF46, 8'h00, 1'b1, 1'b0);
      chk("reset_active", 32'(dma_active), 32'd0);
      chk("reset_dma_reg", 32'(cpu_rdata), 32'hFF);
      chk("reset_no_mem_rd", 32'(mem_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // routing table, all with i_Enable low so the state machine holds
      tbl.push_back('{16'h8000, 8'h00, 1'b0, 1'b0, mem_f(16'h8000), 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'h8000, 8'h00, 1'b1, 1'b0, mem_f(16'h8000), 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16'h8000, 8'h12, 1'b0, 1'b1, mem_f(16'h8000), 1'b0, 1'b1, 1'b0});
      tbl.push_back('{16'hFF46, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF46, 8'h33, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF46, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF81, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{16'hFF81, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF90, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{16'hFF90, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF7F, 8'h00, 1'b1, 1'b0, mem_f(16'hFF7F), 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16'hFFFF, 8'h00, 1'b1, 1'b0, mem_f(16'hFFFF), 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16'hFFFE, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{16'hFFFE, 8'h00, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF80, 8'h99, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{16'hFF80, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{16'hFF45, 8'h00, 1'b1, 1'b0, mem_f(16'hFF45), 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16'hFF47, 8'hAB, 1'b0, 1'b1, mem_f(16'hFF47), 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < tbl.size(); i++) begin
         step(1'b0, tbl[i].addr, tbl[i].data, tbl[i].rd, tbl[i].wr);
         chk($sformatf("tbl%0d_cpu_data", i), 32'(cpu_rdata), 32'(tbl[i].e_cpu));
         chk($sformatf("tbl%0d_mem_rd", i), 32'(mem_rd), 32'(tbl[i].e_mrd));
         chk($sformatf("tbl%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].e_mwr));
         chk($sformatf("tbl%0d_hram_wr", i), 32'(hram_wr), 32'(tbl[i].e_hwr));
         chk($sformatf("tbl%0d_active", i), 32'(dma_active), 32'd0);
         if (tbl[i].e_mrd || tbl[i].e_mwr)
            chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
         if (tbl[i].e_mwr) chk($sformatf("tbl%0d_mem_data", i), 32'(mem_wdata), 32'(tbl[i].data));
         if (tbl[i].e_hwr) begin
            chk($sformatf("tbl%0d_hram_addr", i), 32'(hram_addr), 32'(tbl[i].addr - 16'hFF80));
            chk($sformatf("tbl%0d_hram_data", i), 32'(hram_wdata), 32'(tbl[i].data));
         end
      end

      obs_on = 1'b1;

      // full transfer from 0xC1
      expect_transfer(8'hC1, LEN, LEN);
      run_full(8'hC1, 1'b0, 0, 8'h00);

      // same transfer with the enable toggling every cycle
      expect_transfer(8'hC1, LEN, LEN);
      run_full(8'hC1, 1'b1, 0, 8'h00);

      // echo RAM source folds 0xE2 to 0xC2; register reads back unchanged
      expect_transfer(8'hE2, LEN, LEN);
      run_full(8'hE2, 1'b0, 0, 8'h00);
      step(1'b1, 16'hFF46, 8'h00, 1'b1, 1'b0);
      chk("dma_reg_readback", 32'(cpu_rdata), 32'hE2);

      // restart during the READ of index 50 with source 0x80
      expect_transfer(8'hC1, 51, 50);
      expect_transfer(8'h80, LEN, LEN);
      run_full(8'hC1, 1'b0, 101, 8'h80);

      // restart on the final WRITE edge: last byte still written, then START
      expect_transfer(8'hC1, LEN, LEN);
      expect_transfer(8'h81, LEN, LEN);
      run_full(8'hC1, 1'b0, 2 * LEN, 8'h81);

      // CPU accesses while DMA owns the bus
      expect_transfer(8'hC1, LEN, LEN);
      step(1'b1, 16'hFF46, 8'hC1, 1'b0, 1'b1);
      repeat (5) step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      step(1'b1, 16'h8000, 8'h00, 1'b1, 1'b0);
      chk("busy_cpu_rd_ff", 32'(cpu_rdata), 32'hFF);
      chk("busy_cpu_rd_blocked", 32'(mem_addr), 32'hC102);
      step(1'b1, 16'hFF90, 8'h55, 1'b0, 1'b1);
      chk("busy_hram_wr", 32'(hram_wr), 32'd1);
      chk("busy_hram_addr", 32'(hram_addr), 32'h10);
      chk("busy_hram_data", 32'(hram_wdata), 32'h55);
      chk("busy_hram_wr_mem_addr", 32'(mem_addr), 32'hFE02);
      step(1'b1, 16'hFF90, 8'h00, 1'b1, 1'b0);
      chk("busy_hram_rd", 32'(cpu_rdata), 32'h55);
      step(1'b1, 16'h8000, 8'hAA, 1'b0, 1'b1);
      chk("busy_cpu_wr_dropped", {8'h00, mem_addr, mem_wdata}, {8'h00, 16'hFE03, mem_f(16'hC103)});
      drain();

      // reset during the READ of index 80
      expect_transfer(8'hC1, 81, 80);
      step(1'b1, 16'hFF46, 8'hC1, 1'b0, 1'b1);
      repeat (1 + 161) step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      chk("pre_reset_active", 32'(dma_active), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_active", 32'(dma_active), 32'd0);
      chk("rst_strobes", 32'({mem_rd, mem_wr, hram_wr}), 32'd0);
      cpu_addr = 16'hFF46; cpu_rd = 1'b1;
      #1;
      chk("rst_dma_reg", 32'(cpu_rdata), 32'hFF);
      cpu_addr = 16'h8000;
      #1;
      chk("rst_pass_rd", 32'(mem_rd), 32'd1);
      chk("rst_pass_addr", 32'(mem_addr), 32'h8000);
      chk("rst_pass_data", 32'(cpu_rdata), 32'(mem_f(16'h8000)));
      cpu_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      chk("post_reset_active", 32'(dma_active), 32'd0);
      chk("post_reset_rd_left", 32'(exp_rd_q.size()), 32'd0);
      chk("post_reset_wr_left", 32'(exp_wr_q.size()), 32'd0);

      // randomized phase against the reference model
      obs_on = 1'b0;
      do_reset();
      random_phase(4000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
